// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: bus widths, reset PC, bubble encoding
// and the IF/ID pipeline-register record, used by fetch, decode and hazard.
package riscv_pkg;

    localparam int unsigned     XLEN     = 32;
    localparam int unsigned     IMEM_AW  = 6;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0033;   // add x0,x0,x0

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] inst;
        logic            valid;
    } ifid_t;

    // A bubble carries no PC information so downstream link logic sees zeros.
    function automatic ifid_t ifid_bubble(input logic [XLEN-1:0] nop);
        ifid_t b;
        b.pc    = '0;
        b.pc4   = '0;
        b.inst  = nop;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register with load enable and synchronous bubble insert.
// Bubble insert wins over the enable, so a squash or reset always lands.
// Ports:
//   clk       rising-edge clock
//   en_i      load d_i this edge
//   bubble_i  replace contents with a bubble this edge
//   d_i       incoming record
//   q_o       registered record
module ifid_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INST = riscv_pkg::NOP_INST
) (
    input  logic  clk,
    input  logic  en_i,
    input  logic  bubble_i,
    input  ifid_t d_i,
    output ifid_t q_o
);

    ifid_t ifid_q;

    always_ff @(posedge clk) begin
        if (bubble_i) begin
            ifid_q <= ifid_bubble(NOP_INST);
        end else if (en_i) begin
            ifid_q <= d_i;
        end
    end

    assign q_o = ifid_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage of the 5-stage RV32I pipeline. Owns the PC, addresses InstMem
// (combinational read) and registers the fetched word into IF/ID.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall_i           hold PC and IF/ID
//   branch_taken_i    redirect fetch to branch_target_i, squash IF/ID
//   branch_target_i   redirect byte address
//   imem_offset_o     InstMem word index = pc_o[IMEM_AW+1:2]
//   imem_data_i       InstMem word at imem_offset_o
//   pc_o              current fetch PC
//   ifid_pc_o/pc4_o   PC (and PC+4) of the instruction in IF/ID
//   ifid_inst_o       instruction in IF/ID
//   ifid_valid_o      IF/ID holds a real instruction
//   misalign_o        sticky flag: a redirect target was not word aligned
//   fetch_count_o     valid instructions loaded into IF/ID (wraps)
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
    parameter int unsigned     IMEM_AW  = riscv_pkg::IMEM_AW,
    parameter logic [XLEN-1:0] NOP_INST = riscv_pkg::NOP_INST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               branch_taken_i,
    input  logic [XLEN-1:0]    branch_target_i,
    output logic [IMEM_AW-1:0] imem_offset_o,
    input  logic [XLEN-1:0]    imem_data_i,
    output logic [XLEN-1:0]    pc_o,
    output logic [XLEN-1:0]    ifid_pc_o,
    output logic [XLEN-1:0]    ifid_pc4_o,
    output logic [XLEN-1:0]    ifid_inst_o,
    output logic               ifid_valid_o,
    output logic               misalign_o,
    output logic [XLEN-1:0]    fetch_count_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cnt_q, cnt_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] pc_plus4;
    logic            advance;
    ifid_t           ifid_d, ifid_q;

    assign pc_plus4 = pc_q + 32'd4;
    // A redirect overrides a stall so the branch is never lost.
    assign advance  = !branch_taken_i && !stall_i;

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        mis_d = mis_q;
        if (branch_taken_i) begin
            pc_d  = {branch_target_i[XLEN-1:2], 2'b00};
            mis_d = mis_q | (|branch_target_i[1:0]);
        end else if (!stall_i) begin
            pc_d  = pc_plus4;
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            mis_q <= mis_d;
        end
    end

    always_comb begin
        ifid_d.pc    = pc_q;
        ifid_d.pc4   = pc_plus4;
        ifid_d.inst  = imem_data_i;
        ifid_d.valid = 1'b1;
    end

    ifid_reg #(
        .NOP_INST (NOP_INST)
    ) u_ifid_reg (
        .clk      (clk),
        .en_i     (advance),
        .bubble_i (branch_taken_i | rst),
        .d_i      (ifid_d),
        .q_o      (ifid_q)
    );

    assign imem_offset_o = pc_q[IMEM_AW+1:2];
    assign pc_o          = pc_q;
    assign ifid_pc_o     = ifid_q.pc;
    assign ifid_pc4_o    = ifid_q.pc4;
    assign ifid_inst_o   = ifid_q.inst;
    assign ifid_valid_o  = ifid_q.valid;
    assign misalign_o    = mis_q;
    assign fetch_count_o = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit with a 64-word InstMem model, a directed vector
// table, hand sequences for reset corners, and a random run against a
// behavioural model of the fetch rules.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic [5:0]  offset;
    logic [31:0] imem_data;
    logic [31:0] pc, ipc, ipc4, inst, cnt;
    logic        valid, mis;

    logic [31:0] mem [64];
    assign imem_data = mem[offset];

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (6),
        .NOP_INST (32'h0000_0033)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall),
        .branch_taken_i  (br),
        .branch_target_i (tgt),
        .imem_offset_o   (offset),
        .imem_data_i     (imem_data),
        .pc_o            (pc),
        .ifid_pc_o       (ipc),
        .ifid_pc4_o      (ipc4),
        .ifid_inst_o     (inst),
        .ifid_valid_o    (valid),
        .misalign_o      (mis),
        .fetch_count_o   (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_ipc, m_ipc4, m_inst, m_cnt;
    logic        m_valid, m_mis;

    typedef struct {
        logic        rst, stall, br;
        logic [31:0] tgt;
        logic [31:0] pc, ipc, ipc4, inst;
        logic        valid;
        logic [31:0] cnt;
        logic        mis;
        logic [5:0]  off;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic r, s, b, input logic [31:0] t,
                                input logic [31:0] p, ip, ip4, ins,
                                input logic v, input logic [31:0] c,
                                input logic m, input logic [5:0] o);
        vec_t x;
        x.rst = r; x.stall = s; x.br = b; x.tgt = t;
        x.pc = p; x.ipc = ip; x.ipc4 = ip4; x.inst = ins;
        x.valid = v; x.cnt = c; x.mis = m; x.off = o;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, e_ipc, e_ipc4, e_inst,
                           input logic e_valid, input logic [31:0] e_cnt,
                           input logic e_mis, input logic [5:0] e_off);
        chk({tag, " pc"},    pc,             e_pc);
        chk({tag, " ifpc"},  ipc,            e_ipc);
        chk({tag, " ifpc4"}, ipc4,           e_ipc4);
        chk({tag, " inst"},  inst,           e_inst);
        chk({tag, " valid"}, {31'd0, valid}, {31'd0, e_valid});
        chk({tag, " count"}, cnt,            e_cnt);
        chk({tag, " mis"},   {31'd0, mis},   {31'd0, e_mis});
        chk({tag, " off"},   {26'd0, offset},{26'd0, e_off});
    endtask

    // Fetch rules: reset, then redirect, then stall, else advance.
    task automatic model_step(input logic r, s, b, input logic [31:0] t);
        logic [31:0] word;
        word = mem[m_pc[7:2]];
        if (r) begin
            m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_inst = 32'h33;
            m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
        end else if (b) begin
            m_pc = t & 32'hFFFF_FFFC;
            m_ipc = 32'h0; m_ipc4 = 32'h0; m_inst = 32'h33; m_valid = 1'b0;
            if (t[1:0] != 2'b00) m_mis = 1'b1;
        end else if (!s) begin
            m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_inst = word; m_valid = 1'b1;
            m_cnt = m_cnt + 32'd1;
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic drive(input logic r, s, b, input logic [31:0] t);
        rst = r; stall = s; br = b; tgt = t;
        model_step(r, s, b, t);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = '0;
        mem[0] = 32'h0000_0083;
        mem[1] = 32'h0140_0113;
        for (int unsigned i = 2; i < 64; i++) mem[i] = 32'h0000_0013 | (i << 20);
        m_pc = '0; m_ipc = '0; m_ipc4 = '0; m_inst = 32'h33;
        m_valid = 1'b0; m_mis = 1'b0; m_cnt = '0;

        //           r s b tgt      pc       ifpc     ifpc4    inst          v cnt m off
        tbl[0]  = mk(1,0,0,32'h0,   32'h0,   32'h0,   32'h0,   32'h0000_0033,0,0,  0,0);
        tbl[1]  = mk(0,0,0,32'h0,   32'h4,   32'h0,   32'h4,   32'h0000_0083,1,1,  0,1);
        tbl[2]  = mk(0,0,0,32'h0,   32'h8,   32'h4,   32'h8,   32'h0140_0113,1,2,  0,2);
        tbl[3]  = mk(0,1,0,32'h0,   32'h8,   32'h4,   32'h8,   32'h0140_0113,1,2,  0,2);
        tbl[4]  = mk(0,1,0,32'h0,   32'h8,   32'h4,   32'h8,   32'h0140_0113,1,2,  0,2);
        tbl[5]  = mk(0,0,0,32'h0,   32'hC,   32'h8,   32'hC,   32'h0020_0013,1,3,  0,3);
        tbl[6]  = mk(0,0,1,32'h10,  32'h10,  32'h0,   32'h0,   32'h0000_0033,0,3,  0,4);
        tbl[7]  = mk(0,0,0,32'h0,   32'h14,  32'h10,  32'h14,  32'h0040_0013,1,4,  0,5);
        tbl[8]  = mk(0,1,1,32'h14,  32'h14,  32'h0,   32'h0,   32'h0000_0033,0,4,  0,5);
        tbl[9]  = mk(0,0,0,32'h0,   32'h18,  32'h14,  32'h18,  32'h0050_0013,1,5,  0,6);
        tbl[10] = mk(0,0,1,32'hFE,  32'hFC,  32'h0,   32'h0,   32'h0000_0033,0,5,  1,63);
        tbl[11] = mk(0,0,0,32'h0,   32'h100, 32'hFC,  32'h100, 32'h03F0_0013,1,6,  1,0);
        tbl[12] = mk(0,0,0,32'h0,   32'h104, 32'h100, 32'h104, 32'h0000_0083,1,7,  1,1);
        tbl[13] = mk(0,1,0,32'h0,   32'h104, 32'h100, 32'h104, 32'h0000_0083,1,7,  1,1);
        tbl[14] = mk(1,1,0,32'h0,   32'h0,   32'h0,   32'h0,   32'h0000_0033,0,0,  0,0);

        for (int unsigned i = 0; i < 15; i++) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].br, tbl[i].tgt);
            chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].ipc, tbl[i].ipc4, tbl[i].inst,
                    tbl[i].valid, tbl[i].cnt, tbl[i].mis, tbl[i].off);
        end

        // Reset during a stall with five instructions fetched
        for (int unsigned i = 0; i < 5; i++) drive(0, 0, 0, 32'h0);
        chk("seq6 count before", cnt, 32'd5);
        drive(0, 1, 1, 32'h2A);                 // misaligned redirect sets flag
        drive(0, 1, 0, 32'h0);
        chk("seq6 mis set", {31'd0, mis}, 32'd1);
        drive(1, 1, 0, 32'h0);
        chk_all("seq6 rst", 32'h0, 32'h0, 32'h0, 32'h33, 0, 32'h0, 0, 6'd0);
        // Reset beats a simultaneous misaligned redirect
        drive(1, 0, 1, 32'h33);
        chk_all("rstbr", 32'h0, 32'h0, 32'h0, 32'h33, 0, 32'h0, 0, 6'd0);
        // Back-to-back redirects: last target wins, IF/ID stays a bubble
        drive(0, 0, 1, 32'h40);
        drive(0, 0, 1, 32'h80);
        chk_all("b2b", 32'h80, 32'h0, 32'h0, 32'h33, 0, 32'h0, 0, 6'd32);
        drive(0, 0, 0, 32'h0);
        chk_all("b2b next", 32'h84, 32'h80, 32'h84, 32'h0200_0013, 1, 32'h1, 0, 6'd33);
        // PC wrap modulo 2^32
        drive(0, 0, 1, 32'hFFFF_FFFC);
        drive(0, 0, 0, 32'h0);
        chk_all("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h03F0_0013, 1, 32'h2, 0, 6'd0);

        // Randomised run against the model
        drive(1, 0, 0, 32'h0);
        for (int unsigned i = 0; i < 600; i++) begin
            logic r, s, b;
            logic [31:0] t;
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 30);
            b = ($urandom_range(0, 99) < 12);
            if ($urandom_range(0, 9) == 0) t = $urandom;
            else                           t = {23'd0, 9'($urandom_range(0, 511))};
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            drive(r, s, b, t);
            chk_all($sformatf("rnd%0d", i), m_pc, m_ipc, m_ipc4, m_inst, m_valid, m_cnt,
                    m_mis, m_pc[7:2]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
